// File: rtl/exe_stage_pkg.sv
// Shared bus widths, field layouts and ALU opcode positions for the execute stage.
package exe_stage_pkg;

  localparam int DS_TO_ES_BUS_WD = 136;
  localparam int ES_TO_MS_BUS_WD = 71;
  localparam int ES_TO_ID_BYPASS = 39;
  localparam int ALU_OP_WD       = 12;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_XOR  = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_idx_e;

  typedef struct packed {
    logic [ALU_OP_WD-1:0] alu_op;
    logic                 load_op;
    logic                 src1_is_sa;
    logic                 src1_is_pc;
    logic                 src2_is_imm;
    logic                 src2_is_8;
    logic                 gr_we;
    logic                 mem_we;
    logic [4:0]           dest;
    logic [15:0]          imm;
    logic [31:0]          rs_value;
    logic [31:0]          rt_value;
    logic [31:0]          pc;
  } ds_to_es_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  dest;
    logic        is_load;
    logic [31:0] alu_result;
  } es_to_id_t;

endpackage

// File: rtl/exe_stage_if.sv
// Pipeline handshake, stage buses and data SRAM request signals around the execute stage.
interface exe_stage_if;
  import exe_stage_pkg::*;

  logic                       ms_allowin;
  logic                       es_allowin;
  logic                       ds_to_es_valid;
  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic [ES_TO_ID_BYPASS-1:0] es_to_id_bypass;
  logic                       data_sram_en;
  logic [3:0]                 data_sram_wen;
  logic [31:0]                data_sram_addr;
  logic [31:0]                data_sram_wdata;

  // The execute stage itself.
  modport slave (
    input  ms_allowin, ds_to_es_valid, ds_to_es_bus,
    output es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_id_bypass,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

  // Surrounding pipeline and memory.
  modport master (
    output ms_allowin, ds_to_es_valid, ds_to_es_bus,
    input  es_allowin, es_to_ms_valid, es_to_ms_bus, es_to_id_bypass,
           data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/exe_stage_alu.sv
// One-hot controlled 32-bit ALU; results of all selected operations are OR-ed together.
module exe_stage_alu
  import exe_stage_pkg::*;
(
  input  logic [ALU_OP_WD-1:0] i_alu_op,
  input  logic [31:0]          i_alu_src1,
  input  logic [31:0]          i_alu_src2,
  output logic [31:0]          o_alu_result
);

  logic [31:0] w_add;
  logic [31:0] w_sub;
  logic [31:0] w_slt;
  logic [31:0] w_sltu;
  logic [31:0] w_sll;
  logic [31:0] w_srl;
  logic [31:0] w_sra;
  logic [31:0] w_lui;

  // src1 carries the shift amount, src2 the shifted value.
  always_comb begin
    w_add  = i_alu_src1 + i_alu_src2;
    w_sub  = i_alu_src1 - i_alu_src2;
    w_slt  = {31'd0, ($signed(i_alu_src1) < $signed(i_alu_src2))};
    w_sltu = {31'd0, (i_alu_src1 < i_alu_src2)};
    w_sll  = i_alu_src2 << i_alu_src1[4:0];
    w_srl  = i_alu_src2 >> i_alu_src1[4:0];
    w_sra  = $signed(i_alu_src2) >>> i_alu_src1[4:0];
    w_lui  = {i_alu_src2[15:0], 16'd0};
    o_alu_result = ({32{i_alu_op[ALU_ADD ]}} & w_add)
                 | ({32{i_alu_op[ALU_SUB ]}} & w_sub)
                 | ({32{i_alu_op[ALU_SLT ]}} & w_slt)
                 | ({32{i_alu_op[ALU_SLTU]}} & w_sltu)
                 | ({32{i_alu_op[ALU_AND ]}} & (i_alu_src1 & i_alu_src2))
                 | ({32{i_alu_op[ALU_NOR ]}} & ~(i_alu_src1 | i_alu_src2))
                 | ({32{i_alu_op[ALU_OR  ]}} & (i_alu_src1 | i_alu_src2))
                 | ({32{i_alu_op[ALU_XOR ]}} & (i_alu_src1 ^ i_alu_src2))
                 | ({32{i_alu_op[ALU_SLL ]}} & w_sll)
                 | ({32{i_alu_op[ALU_SRL ]}} & w_srl)
                 | ({32{i_alu_op[ALU_SRA ]}} & w_sra)
                 | ({32{i_alu_op[ALU_LUI ]}} & w_lui);
  end

endmodule

// File: rtl/exe_stage.sv
// Single-cycle execute stage: holds one instruction, computes its ALU result,
// issues the data SRAM request and forwards the result to MEM and the decode bypass.
module exe_stage
  import exe_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  exe_stage_if.slave es_if
);

  ds_to_es_t   r_bus;
  logic        r_es_valid;
  logic        w_es_ready_go;
  logic        w_es_allowin;
  logic [31:0] w_src1;
  logic [31:0] w_src2;
  logic [31:0] w_alu_result;
  es_to_ms_t   w_to_ms;
  es_to_id_t   w_bypass;

  assign w_es_ready_go = 1'b1;
  assign w_es_allowin  = !r_es_valid || (w_es_ready_go && es_if.ms_allowin);

  // Stage occupancy; reset discards any in-flight instruction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_es_valid <= 1'b0;
    end else if (w_es_allowin) begin
      r_es_valid <= es_if.ds_to_es_valid;
    end
  end

  // Instruction register only changes on an accepted transfer, so a stall keeps it stable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus <= '0;
    end else if (es_if.ds_to_es_valid && w_es_allowin) begin
      r_bus <= ds_to_es_t'(es_if.ds_to_es_bus);
    end
  end

  // ALU operand selection.
  always_comb begin
    if (r_bus.src1_is_sa) begin
      w_src1 = {27'd0, r_bus.imm[10:6]};
    end else if (r_bus.src1_is_pc) begin
      w_src1 = r_bus.pc;
    end else begin
      w_src1 = r_bus.rs_value;
    end
    if (r_bus.src2_is_imm) begin
      w_src2 = {{16{r_bus.imm[15]}}, r_bus.imm};
    end else if (r_bus.src2_is_8) begin
      w_src2 = 32'd8;
    end else begin
      w_src2 = r_bus.rt_value;
    end
  end

  exe_stage_alu u_alu (
    .i_alu_op     (r_bus.alu_op),
    .i_alu_src1   (w_src1),
    .i_alu_src2   (w_src2),
    .o_alu_result (w_alu_result)
  );

  assign w_to_ms.res_from_mem = r_bus.load_op;
  assign w_to_ms.gr_we        = r_bus.gr_we;
  assign w_to_ms.dest         = r_bus.dest;
  assign w_to_ms.alu_result   = w_alu_result;
  assign w_to_ms.pc           = r_bus.pc;

  assign w_bypass.valid       = r_es_valid && r_bus.gr_we;
  assign w_bypass.dest        = r_bus.dest;
  assign w_bypass.is_load     = r_bus.load_op;
  assign w_bypass.alu_result  = w_alu_result;

  assign es_if.es_allowin      = w_es_allowin;
  assign es_if.es_to_ms_valid  = r_es_valid && w_es_ready_go;
  assign es_if.es_to_ms_bus    = w_to_ms;
  assign es_if.es_to_id_bypass = w_bypass;

  // Loads and stores are both issued from here; a store repeats harmlessly while stalled.
  assign es_if.data_sram_en    = 1'b1;
  assign es_if.data_sram_wen   = (r_bus.mem_we && r_es_valid) ? 4'hf : 4'h0;
  assign es_if.data_sram_addr  = w_alu_result;
  assign es_if.data_sram_wdata = r_bus.rt_value;

endmodule
